// File: rtl/shift_led_pkg.sv
// ---------------------------------------------------------------------------
// shift_led_pkg : mode encoding, bounce direction and counter sizing helper
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_led_pkg;

  localparam logic [2:0] MODE_HOLD   = 3'd0;
  localparam logic [2:0] MODE_SHL    = 3'd1;
  localparam logic [2:0] MODE_SHR    = 3'd2;
  localparam logic [2:0] MODE_ROTL   = 3'd3;
  localparam logic [2:0] MODE_ROTR   = 3'd4;
  localparam logic [2:0] MODE_LOAD   = 3'd5;
  localparam logic [2:0] MODE_BOUNCE = 3'd6;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int clog2(input int unsigned value);
    int          r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen : clock-enable pulse every DIV enabled cycles, frozen while en=0
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_gen
  import shift_led_pkg::*;
#(
  parameter int DIV = 25_000_000
) (
  input  logic CLK,
  input  logic rs,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;
  // armed_q is high while the counter sits at its last value
  logic          armed_q, armed_d;

  always_comb begin
    count_d = count_q;
    armed_d = armed_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
      armed_d = (count_d == LAST);
    end
  end

  always_ff @(posedge CLK or posedge rs) begin
    if (rs) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

  assign tick = armed_q & en;

endmodule

`default_nettype wire

// File: rtl/shift_led_ctrl.sv
// ---------------------------------------------------------------------------
// shift_led_ctrl : tick-paced LED shift / rotate / load / bounce controller
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_led_ctrl
  import shift_led_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 25_000_000
) (
  input  logic             CLK,
  input  logic             rs,
  input  logic             din,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             dir
);

  logic             tick_w;
  logic             led_onehot;
  logic [WIDTH-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  logic [2:0]       last_mode_q, last_mode_d;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .rs   (rs),
    .en   (en),
    .tick (tick_w)
  );

  assign led_onehot = (led_q != '0) && ((led_q & (led_q - WIDTH'(1))) == '0);

  always_comb begin
    led_d       = led_q;
    dir_d       = dir_q;
    last_mode_d = last_mode_q;
    if (tick_w) begin
      last_mode_d = mode;
      case (mode)
        MODE_SHL:  led_d = {led_q[WIDTH-2:0], din};
        MODE_SHR:  led_d = {din, led_q[WIDTH-1:1]};
        MODE_ROTL: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        MODE_ROTR: led_d = {led_q[0], led_q[WIDTH-1:1]};
        MODE_LOAD: led_d = pdata;
        MODE_BOUNCE: begin
          // Re-seed whenever bounce was not running or the pattern is corrupt
          if ((last_mode_q != MODE_BOUNCE) || !led_onehot) begin
            led_d = WIDTH'(1);
            dir_d = DIR_UP;
          end else if (dir_q == DIR_UP) begin
            if (led_q[WIDTH-1]) begin
              dir_d = DIR_DOWN;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DIR_UP;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default: led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge rs) begin
    if (rs) begin
      led_q       <= '0;
      dir_q       <= DIR_UP;
      last_mode_q <= MODE_HOLD;
    end else begin
      led_q       <= led_d;
      dir_q       <= dir_d;
      last_mode_q <= last_mode_d;
    end
  end

  assign led  = led_q;
  assign dir  = dir_q;
  assign tick = tick_w;

endmodule

`default_nettype wire

// File: tb/tb_shift_led_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_led_ctrl : directed + randomized bench with a behavioural LED model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_led_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLK   = 1'b0;
  logic         rs    = 1'b1;
  logic         din   = 1'b0;
  logic         en    = 1'b0;
  logic [2:0]   mode  = 3'd0;
  logic [W-1:0] pdata = '0;
  logic [W-1:0] led;
  logic         tick;
  logic         dir;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  logic [W-1:0] m_led;
  bit           m_dir;
  int           m_last;
  int           m_en_cycles;
  bit           exp_tick;

  logic [7:0] bexp [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  bit         dexp [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};

  shift_led_ctrl #(
    .WIDTH (W),
    .DIV   (D)
  ) dut (
    .CLK   (CLK),
    .rs    (rs),
    .din   (din),
    .en    (en),
    .mode  (mode),
    .pdata (pdata),
    .led   (led),
    .tick  (tick),
    .dir   (dir)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern update expressed as integer arithmetic / LED position
  task automatic model_update(input int md, input bit d, input logic [W-1:0] p);
    int v;
    int mask;
    int pos;
    mask = (1 << W) - 1;
    v    = int'(m_led);
    case (md)
      1: v = ((v << 1) | int'(d)) & mask;
      2: v = (v >> 1) | (int'(d) << (W - 1));
      3: v = ((v << 1) | (v >> (W - 1))) & mask;
      4: v = (v >> 1) | ((v & 1) << (W - 1));
      5: v = int'(p);
      6: begin
        if (m_last != 6 || $countones(m_led) != 1) begin
          v     = 1;
          m_dir = 1'b0;
        end else begin
          pos = $clog2(v);
          if (!m_dir) begin
            if (pos == W - 1) begin m_dir = 1'b1; pos = pos - 1; end
            else pos = pos + 1;
          end else begin
            if (pos == 0) begin m_dir = 1'b0; pos = pos + 1; end
            else pos = pos - 1;
          end
          v = 1 << pos;
        end
      end
      default: v = v;
    endcase
    m_led  = v[W-1:0];
    m_last = md;
  endtask

  always @(negedge CLK) begin
    if (started) begin
      if (rs) begin
        m_led       = '0;
        m_dir       = 1'b0;
        m_last      = 0;
        m_en_cycles = 0;
      end
      exp_tick = !rs && en && ((m_en_cycles % D) == D - 1);
      chk("model_led", led, m_led);
      chk("model_dir", dir, m_dir);
      chk("model_tick", tick, exp_tick);
      if (!rs && en) begin
        if (exp_tick) model_update(int'(mode), din, pdata);
        m_en_cycles++;
      end
    end
  end

  // Present inputs, wait (bounded) for the tick that samples them, land just after the update edge
  task automatic step(input logic [2:0] m, input bit d, input logic [W-1:0] p);
    int n;
    n     = 0;
    mode  = m;
    din   = d;
    pdata = p;
    do begin
      @(negedge CLK);
      n++;
    end while (!tick && n < 50);
    chk("tick_seen", tick, 1'b1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rs = 1'b1;
    @(posedge CLK);
    #1;
    started = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    rs   = 1'b0;
    en   = 1'b1;
    mode = 3'd0;

    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      chk("tick_cycle", tick, (c % 4) == 0);
      chk("hold_led", led, 8'h00);
    end
    @(posedge CLK);
    #1;

    step(3'd1, 1'b1, 8'h00); chk("shl_1", led, 8'h01);
    step(3'd1, 1'b1, 8'h00); chk("shl_2", led, 8'h03);
    step(3'd1, 1'b1, 8'h00); chk("shl_3", led, 8'h07);
    step(3'd1, 1'b0, 8'h00); chk("shl_4", led, 8'h0E);

    step(3'd5, 1'b0, 8'h81); chk("load", led, 8'h81);
    step(3'd3, 1'b1, 8'h00); chk("rotl_1", led, 8'h03);
    step(3'd3, 1'b1, 8'h00); chk("rotl_2", led, 8'h06);
    step(3'd4, 1'b1, 8'h00); chk("rotr_1", led, 8'h03);

    step(3'd5, 1'b0, 8'hA5); chk("load_a5", led, 8'hA5);
    for (int i = 0; i < 15; i++) begin
      step(3'd6, 1'b0, 8'h00);
      chk("bounce_led", led, bexp[i]);
      chk("bounce_dir", dir, dexp[i]);
    end
    step(3'd6, 1'b0, 8'h00);
    chk("bounce_turn_led", led, 8'h02);
    chk("bounce_turn_dir", dir, 1'b0);

    @(posedge CLK);
    #1;
    en = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      chk("freeze_tick", tick, 1'b0);
      chk("freeze_led", led, 8'h02);
    end
    @(posedge CLK);
    #1;
    en = 1'b1;
    step(3'd6, 1'b0, 8'h00); chk("resume_led", led, 8'h04);
    step(3'd6, 1'b0, 8'h00); chk("pre_rst_8", led, 8'h08);
    step(3'd6, 1'b0, 8'h00); chk("pre_rst_10", led, 8'h10);

    rs = 1'b1;
    #2;
    chk("async_rst_led", led, 8'h00);
    chk("async_rst_dir", dir, 1'b0);
    @(posedge CLK);
    #1;
    rs = 1'b0;
    step(3'd6, 1'b0, 8'h00); chk("reentry_led", led, 8'h01);

    mode = 3'd6;
    repeat (3000) begin
      @(posedge CLK);
      #1;
      rs  = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 9) != 0);
      din = 1'($urandom);
      if ($urandom_range(0, 15) == 0) pdata = W'($urandom);
      if ($urandom_range(0, 23) == 0) mode = 3'($urandom_range(0, 7));
    end
    rs = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
